// File: rtl/rf_pkg.sv
// Shared types and helpers for the multiport register file.
package rf_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  // Widest word byte_merge can handle; callers zero-extend and truncate.
  localparam int unsigned RF_MAX_W  = 128;

  typedef enum logic [0:0] {RF_IDLE, RF_CLEAR} rf_state_e;

  // Byte-wise merge: byte b comes from new_word when be[b] is set, else from old_word.
  function automatic logic [RF_MAX_W-1:0] byte_merge(input logic [RF_MAX_W-1:0]   old_word,
                                                     input logic [RF_MAX_W-1:0]   new_word,
                                                     input logic [RF_MAX_W/8-1:0] be);
    logic [RF_MAX_W-1:0] res;
    res = old_word;
    for (int unsigned b = 0; b < RF_MAX_W / 8; b++) begin
      if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/multiport_register_file_if.sv
// Read/write/clear bus of the multiport register file.
interface multiport_register_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [DATA_W/8-1:0]      wr_be;
  logic                     wr_ready;
  logic                     clr_req;
  logic                     clr_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_be, clr_req,
    input  rd_data, wr_ready, clr_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_be, clr_req,
    output rd_data, wr_ready, clr_busy
  );
endinterface

// File: rtl/rf_clear_seq.sv
// Bulk-clear sequencer: walks every address once, issuing a zero write per cycle.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; terminal compare ends the sweep before the counter can wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
      RF_CLEAR: begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RF_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  assign clr_busy = (state_q == RF_CLEAR);
  assign clr_we   = clr_busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/multiport_register_file.sv
// Parametrised register file: NUM_RD registered read ports with write-first bypass,
// one byte-enabled write port and a sequenced bulk clear.
// Optional macro RF_ZERO_REG_EN hardwires register 0 to zero.
module multiport_register_file
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NUM_RD = 2
) (
  input logic                       clk,
  input logic                       rst_n,
  multiport_register_file_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic                     clr_busy, clr_we;
  logic [ADDR_W-1:0]        clr_addr;
  logic                     wr_acc, wr_zero_hit;
  logic [DATA_W-1:0]        wr_merged;

  rf_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (bus.clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

`ifdef RF_ZERO_REG_EN
  assign wr_zero_hit = (bus.wr_addr == '0);
`else
  assign wr_zero_hit = 1'b0;
`endif

  // A write issued while clearing is dropped; the master watches wr_ready.
  assign wr_acc    = bus.wr_en && !clr_busy && !wr_zero_hit;
  assign wr_merged = DATA_W'(byte_merge(RF_MAX_W'(mem_q[bus.wr_addr]), RF_MAX_W'(bus.wr_data),
                                        (RF_MAX_W/8)'(bus.wr_be)));

  // Read value as it will be after this edge's write or clear (write-first bypass).
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
    ra        = '0;
    rv        = '0;
    rd_data_d = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
      rv = mem_q[ra];
      if (wr_acc && (bus.wr_addr == ra)) rv = wr_merged;
      if (clr_we && (clr_addr == ra)) rv = '0;
`ifdef RF_ZERO_REG_EN
      if (ra == '0) rv = '0;
`endif
      rd_data_d[k*DATA_W +: DATA_W] = rv;
    end
  end

  // Storage array and registered read data; clear and external write never coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      if (clr_we) begin
        mem_q[clr_addr] <= '0;
      end else if (wr_acc) begin
        mem_q[bus.wr_addr] <= wr_merged;
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.clr_busy = clr_busy;
  assign bus.wr_ready = ~clr_busy;

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file (default 32-bit, 32 entries, 2 read ports).
module tb_multiport_register_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cycles;

  always #5 clk = ~clk;

  multiport_register_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

  multiport_register_file #(
    .DATA_W (32),
    .ADDR_W (5),
    .NUM_RD (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_be   = be;
  endtask

  function automatic logic [31:0] rd0();
    return bus.rd_data[31:0];
  endfunction

  function automatic logic [31:0] rd1();
    return bus.rd_data[63:32];
  endfunction

  initial begin
    logic [31:0] zexp;
    bus.rd_addr = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_be   = '0;
    bus.clr_req = 1'b0;

    // Reset, read address 5 on both ports.
    set_rd(5'd5, 5'd5);
    step();
    rst_n = 1'b1;
    check("reset_rd0", rd0(), 32'h0);
    check("reset_rd1", rd1(), 32'h0);
    check("reset_wr_ready", {31'b0, bus.wr_ready}, 32'd1);
    check("reset_clr_busy", {31'b0, bus.clr_busy}, 32'd0);
    step();
    check("idle_rd0", rd0(), 32'h0);

    // Full write then low-byte write to address 3, with bypass.
    set_rd(5'd3, 5'd5);
    write(5'd3, 32'hDEADBEEF, 4'b1111);
    step();
    check("wr_full_bypass", rd0(), 32'hDEADBEEF);
    write(5'd3, 32'h000000AA, 4'b0001);
    step();
    check("wr_byte_bypass", rd0(), 32'hDEADBEAA);
    write(5'd3, 32'h11223344, 4'b0000);
    step();
    bus.wr_en = 1'b0;
    check("wr_be_zero", rd0(), 32'hDEADBEAA);
    step();
    check("wr_byte_stored", rd0(), 32'hDEADBEAA);

    // Same-cycle write and dual read of address 7.
    set_rd(5'd7, 5'd7);
    write(5'd7, 32'h12345678, 4'b1111);
    step();
    bus.wr_en = 1'b0;
    check("bypass_p0", rd0(), 32'h12345678);
    check("bypass_p1", rd1(), 32'h12345678);

    // Fill 1..31 with their index.
    for (int a = 1; a < 32; a++) begin
      write(5'(a), 32'(a), 4'b1111);
      step();
    end
    bus.wr_en = 1'b0;
    set_rd(5'd31, 5'd1);
    step();
    check("fill_rd31", rd0(), 32'd31);
    check("fill_rd1", rd1(), 32'd1);

    // Bulk clear: busy exactly 32 cycles, mid-clear write dropped, clear bypasses to reads.
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    check("clr_busy_high", {31'b0, bus.clr_busy}, 32'd1);
    check("clr_wr_ready_low", {31'b0, bus.wr_ready}, 32'd0);
    cycles = 0;
    while (bus.clr_busy && cycles < 100) begin
      if (cycles == 5) write(5'd1, 32'h00000055, 4'b1111);
      else bus.wr_en = 1'b0;
      set_rd(5'(cycles), 5'd0);
      step();
      check("clr_bypass", rd0(), 32'h0);
      cycles++;
    end
    bus.wr_en = 1'b0;
    check("clr_busy_cycles", 32'(cycles), 32'd32);
    check("clr_done_ready", {31'b0, bus.wr_ready}, 32'd1);
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      step();
      check("post_clr_p0", rd0(), 32'h0);
      check("post_clr_p1", rd1(), 32'h0);
    end

    // Reset mid-clear at counter 10.
    write(5'd20, 32'h000000A5, 4'b1111);
    step();
    write(5'd25, 32'h00000077, 4'b1111);
    step();
    bus.wr_en   = 1'b0;
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    set_rd(5'd20, 5'd25);
    step();
    rst_n = 1'b1;
    check("rst_mid_busy", {31'b0, bus.clr_busy}, 32'd0);
    check("rst_mid_ready", {31'b0, bus.wr_ready}, 32'd1);
    step();
    check("rst_mid_reg20", rd0(), 32'h0);
    check("rst_mid_reg25", rd1(), 32'h0);

    // New clear restarts from counter 0.
    write(5'd3, 32'h00000033, 4'b1111);
    step();
    write(5'd31, 32'h00000031, 4'b1111);
    step();
    bus.wr_en   = 1'b0;
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    set_rd(5'd3, 5'd31);
    step();
    check("restart_reg3", rd0(), 32'h0);
    check("restart_reg31", rd1(), 32'h00000031);
    cycles = 5;
    while (bus.clr_busy && cycles < 100) begin
      step();
      cycles++;
    end
    check("restart_busy_cycles", 32'(cycles), 32'd32);
    step();
    check("restart_reg31_cleared", rd1(), 32'h0);

    // Register 0 behaviour.
`ifdef RF_ZERO_REG_EN
    zexp = 32'h0;
`else
    zexp = 32'hFFFFFFFF;
`endif
    set_rd(5'd0, 5'd0);
    write(5'd0, 32'hFFFFFFFF, 4'b1111);
    step();
    bus.wr_en = 1'b0;
    check("reg0_bypass", rd0(), zexp);
    step();
    check("reg0_stored", rd1(), zexp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiport_register_file.md
Name: multiport_register_file

Overview:
- Parametrised successor to the two-read/one-write CPU register file: configurable data width, depth and read-port count.
- Adds byte-enable writes, write-to-read bypass and a sequenced bulk clear.
- Sits in the multi-cycle MIPS datapath between decode (read addresses) and writeback (write port).
- Registered read outputs keep one-cycle read latency.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports, 1..4.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k in bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  registered read data; port k in bits [k*DATA_W +: DATA_W].
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit b selects byte b.
- wr_ready  out  1  high when external writes are accepted (= ~clr_busy).
- clr_req  in  1  single-cycle request to zero the whole array.
- clr_busy  out  1  clear sequence in progress.

Behaviour:
- Reset (rst_n=0 at an edge): all DEPTH registers, rd_data, clr_busy and the clear counter go to 0. wr_ready=1 the cycle after. Reset overrides every other input, including mid-clear: the sequence aborts and the array is zero.
- Write: at an edge with wr_en=1 and clr_busy=0, for each byte b with wr_be[b]=1, reg[wr_addr] byte b <= wr_data byte b. Other bytes are unchanged. wr_be=0 means no change.
- Writes while clr_busy=1: dropped silently. The master must check wr_ready.
- Read: at every edge, rd_data[k] <= value of reg[rd_addr[k]] after that edge's write (write-first bypass). If an accepted write targets rd_addr[k] in the same cycle, rd_data[k] gets the byte-merged new value, not the old one. Latency is 1 cycle; there is no read enable.
- Multiple read ports on the same address return identical data.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clr_req=1 -> CLEAR; counter=0; clr_busy=1 from the next edge.
  - CLEAR: each edge writes 0 to reg[counter] and increments the counter. When counter==DEPTH-1 has been written, go to IDLE; clr_busy=0 on that same edge.
  - Total busy time is exactly DEPTH cycles.
  - clr_req in CLEAR is ignored (no restart).
  - Clear writes bypass to reads like normal writes: a read of the address being cleared returns 0.
  - Counter is ADDR_W bits; wrap is never reached because the terminal compare precedes it.
- Simultaneous clr_req and wr_en in IDLE: the write is accepted (clr_busy is still 0), then the clear starts. The write is therefore overwritten when its address is cleared.

Optional Feature:
- Macro RF_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - Writes with wr_addr=0 are discarded.
  - Reads of address 0 always return 0, including bypass.
  - Clear still runs DEPTH cycles.
- Undefined: register 0 is ordinary storage.

Decomposition:
- Package rf_pkg:
  - default widths RF_DATA_W=32, RF_ADDR_W=5;
  - clear FSM state enum (RF_IDLE, RF_CLEAR);
  - function byte_merge(old, new, be) returning the merged word, shared by the array write and the bypass path.
- Sub-module rf_clear_seq: owns the FSM, counter and clr_busy; outputs clear write enable and address to the top.

Test Plan:
- Reset then read all ports at addr 5 -> rd_data=0 one cycle after. wr_ready=1, clr_busy=0.
- Write 0xDEADBEEF to addr 3 (be=4'b1111), next cycle write 0x000000AA be=4'b0001 -> read addr 3 returns 0xDEADBEAA.
- Same-cycle wr addr 7 data 0x12345678 and rd_addr[0]=rd_addr[1]=7 -> both ports read 0x12345678 on the next edge (bypass).
- Fill regs 1..31 with their index, pulse clr_req -> clr_busy high exactly 32 cycles. A write issued mid-clear is dropped (wr_ready=0). Afterwards all reads return 0.
- rst_n=0 for one edge during clear at counter=10 -> clr_busy=0, all regs 0 next cycle. A new clr_req restarts from counter 0.
- With RF_ZERO_REG_EN: write 0xFFFFFFFF to addr 0 -> read addr 0 returns 0, including the same-cycle bypass. Without the macro -> returns 0xFFFFFFFF.
